// File: rtl/conv2d_stream.sv
// conv2d_stream -- streaming M_LEN x M_LEN signed fixed-point convolver.
//
// Kernel and image columns share one input bus, with i_selecK_I choosing the
// destination. The kernel loads column by column. Image columns then slide
// through an M_LEN-column window. Once the window is full, every valid image
// column launches one multiply-accumulate through a fixed 3-stage pipeline:
//   S1 products, S2 adder tree, S3 output format.
//
// Optional build macro:
//   CONV_ROUND_EN  defined   -> S3 rounds half-up before truncating and
//                               saturates to the most positive code when the
//                               rounding overflows.
//                  undefined -> S3 truncates toward -inf.
module conv2d_stream #(
  parameter int BIT_LEN   = 8,
  parameter int M_LEN     = 3,
  parameter int CONV_LEN  = 20,
  parameter int CONV_LPOS = 13
) (
  input  logic                       CLK100MHZ,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_selecK_I,
  input  logic [M_LEN*BIT_LEN-1:0]   i_dato,
  output logic [CONV_LPOS-1:0]       o_data,
  output logic                       o_valid,
  output logic                       o_kernel_ok
);

  localparam int CW   = (M_LEN > 1) ? $clog2(M_LEN) : 1;
  localparam int NTAP = M_LEN * M_LEN;
  localparam int PW   = 2 * BIT_LEN;
  localparam logic [CW-1:0] LAST_COL = CW'(M_LEN - 1);

  localparam logic [1:0] KLOAD = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] kcnt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] kidx;
  logic          load_k;
  logic          load_img;
  logic          shift_en;
  logic          launch;
  logic          launch_q;

  logic signed [BIT_LEN-1:0] col_in [M_LEN];
  logic signed [BIT_LEN-1:0] kern   [M_LEN][M_LEN];
  logic signed [BIT_LEN-1:0] win    [M_LEN][M_LEN];

  logic              v1;
  logic signed [PW-1:0] prod [NTAP];
  logic              v2;
  logic [CONV_LEN-1:0] acc;
  logic [CONV_LEN-1:0] sum_q;
  logic [CONV_LPOS-1:0] fmt;

  // Signed multiply done at full product width so no operand extension is implied.
  function automatic logic signed [PW-1:0] smul(input logic signed [BIT_LEN-1:0] a,
                                                input logic signed [BIT_LEN-1:0] b);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = {{BIT_LEN{a[BIT_LEN-1]}}, a};
    bx = {{BIT_LEN{b[BIT_LEN-1]}}, b};
    return ax * bx;
  endfunction

  // Split the input bus into per-row pixels/coefficients, row 0 at the LSBs.
  always_comb begin
    for (int r = 0; r < M_LEN; r++) begin
      col_in[r] = i_dato[r*BIT_LEN +: BIT_LEN];
    end
  end

  // Decode what this cycle's column means given the current mode.
  always_comb begin
    load_k   = i_valid & ~i_selecK_I;
    load_img = i_valid & i_selecK_I;
    // Image columns are dropped in KLOAD until the kernel is complete.
    shift_en = load_img & ((state != KLOAD) | o_kernel_ok);
    // A result launches when the window is, or just became, full.
    launch   = load_img & ((state == RUN) | ((state == FILL) & (wcnt == LAST_COL)));
    // A kernel column arriving outside KLOAD restarts the load at column 0.
    kidx     = (state == KLOAD) ? kcnt : '0;
  end

  // Mode FSM with kernel/window column counters and the kernel-complete flag.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      state       <= KLOAD;
      kcnt        <= '0;
      wcnt        <= '0;
      o_kernel_ok <= 1'b0;
      launch_q    <= 1'b0;
    end else begin
      launch_q <= launch;
      if (load_k) begin
        if (state == KLOAD) begin
          // Once the kernel is complete, extra columns wrap and overwrite from column 0.
          if (kcnt == LAST_COL) begin
            kcnt        <= '0;
            o_kernel_ok <= 1'b1;
          end else begin
            kcnt <= kcnt + CW'(1);
          end
        end else begin
          // Reload: this column becomes K[0] and the window is thrown away.
          state       <= KLOAD;
          kcnt        <= CW'(1);
          o_kernel_ok <= 1'b0;
          wcnt        <= '0;
        end
      end else if (load_img) begin
        case (state)
          KLOAD: begin
            if (o_kernel_ok) begin
              state <= FILL;
              wcnt  <= CW'(1);
            end
          end
          FILL: begin
            if (wcnt == LAST_COL) begin
              state <= RUN;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
          RUN:     state <= RUN;
          default: state <= KLOAD;
        endcase
      end
    end
  end

  // Kernel register file, written one column at a time.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          kern[c][r] <= '0;
        end
      end
    end else if (load_k) begin
      for (int r = 0; r < M_LEN; r++) begin
        kern[kidx][r] <= col_in[r];
      end
    end
  end

  // Sliding window: column 0 is the oldest, and new columns enter at M_LEN-1.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          win[c][r] <= '0;
        end
      end
    end else if (load_k) begin
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          win[c][r] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int c = 0; c < M_LEN - 1; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          win[c][r] <= win[c+1][r];
        end
      end
      for (int r = 0; r < M_LEN; r++) begin
        win[M_LEN-1][r] <= col_in[r];
      end
    end
  end

  // S1: one signed product per tap, taken from the window as it stood at launch.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      v1 <= 1'b0;
      for (int t = 0; t < NTAP; t++) begin
        prod[t] <= '0;
      end
    end else begin
      v1 <= launch_q;
      for (int c = 0; c < M_LEN; c++) begin
        for (int r = 0; r < M_LEN; r++) begin
          prod[c*M_LEN + r] <= smul(win[c][r], kern[c][r]);
        end
      end
    end
  end

  // S2 adder tree: sign-extend every product to accumulator width and add them all.
  always_comb begin
    acc = '0;
    for (int t = 0; t < NTAP; t++) begin
      acc = acc + {{(CONV_LEN-PW){prod[t][PW-1]}}, prod[t]};
    end
  end

  // S2 register stage for the accumulated sum.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      v2    <= 1'b0;
      sum_q <= '0;
    end else begin
      v2    <= v1;
      sum_q <= acc;
    end
  end

`ifdef CONV_ROUND_EN
  localparam logic [CONV_LEN:0] RND_INC = {{CONV_LEN{1'b0}}, 1'b1} << (CONV_LEN - CONV_LPOS - 1);
  logic [CONV_LEN:0] rsum;
  logic              unused_low_bits;

  // S3 format: round half-up, saturate positive overflow, then take the MSBs as offset-binary.
  always_comb begin
    rsum = {sum_q[CONV_LEN-1], sum_q} + RND_INC;
    if (rsum[CONV_LEN] != rsum[CONV_LEN-1]) begin
      fmt = '1;
    end else begin
      fmt = {~rsum[CONV_LEN-1], rsum[CONV_LEN-2 -: CONV_LPOS-1]};
    end
  end

  assign unused_low_bits = ^rsum[CONV_LEN-CONV_LPOS-1:0];
`else
  logic unused_low_bits;

  // S3 format: truncate toward -inf and invert the sign bit to get offset-binary.
  always_comb begin
    fmt = {~sum_q[CONV_LEN-1], sum_q[CONV_LEN-2 -: CONV_LPOS-1]};
  end

  // The accumulator bits below the output LSB are discarded by truncation.
  assign unused_low_bits = ^sum_q[CONV_LEN-CONV_LPOS-1:0];
`endif

  // S3 output register: o_data keeps its last result while o_valid is low.
  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= v2;
      if (v2) begin
        o_data <= fmt;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream -- directed bench for conv2d_stream at default parameters.
// Expected 13-bit results are hand-computed constants, and each one is queued
// with the cycle in which it must appear (launch edge + 3).
module tb_conv2d_stream;

  localparam int BIT_LEN   = 8;
  localparam int M_LEN     = 3;
  localparam int CONV_LEN  = 20;
  localparam int CONV_LPOS = 13;

`ifdef CONV_ROUND_EN
  localparam logic [12:0] EXP_ODD_HALF = 13'h1033;
`else
  localparam logic [12:0] EXP_ODD_HALF = 13'h1032;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        sel;
  logic [23:0] dato;
  logic [12:0] odata;
  logic        ovalid;
  logic        kernelOk;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCnt    = 0;

  int          expCyc[$];
  logic [12:0] expDat[$];
  int          obsCyc[$];
  logic [12:0] obsDat[$];

  conv2d_stream #(
    .BIT_LEN(BIT_LEN),
    .M_LEN(M_LEN),
    .CONV_LEN(CONV_LEN),
    .CONV_LPOS(CONV_LPOS)
  ) dut (
    .CLK100MHZ(clk),
    .i_reset(rst),
    .i_valid(valid),
    .i_selecK_I(sel),
    .i_dato(dato),
    .o_data(odata),
    .o_valid(ovalid),
    .o_kernel_ok(kernelOk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Record every result pulse together with the cycle in which it was seen.
  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      obsCyc.push_back(cycleCnt);
      obsDat.push_back(odata);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [23:0] col(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    return {r2, r1, r0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one column for exactly one rising edge, optionally queueing its result.
  task automatic applyStimulus(input logic v, input logic s, input logic [23:0] d,
                               input logic expLaunch, input logic [12:0] expData);
    @(negedge clk);
    valid = v;
    sel   = s;
    dato  = d;
    if (expLaunch) begin
      expCyc.push_back(cycleCnt + 4);
      expDat.push_back(expData);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic kcol(input logic [23:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 13'h0);
  endtask

  task automatic icol(input logic [23:0] d, input logic launch, input logic [12:0] exp);
    applyStimulus(1'b1, 1'b1, d, launch, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 13'h0);
  endtask

  // Let the pipeline empty, then compare observed results against the queued ones.
  task automatic drainCheck(input string tag);
    int n;
    idle(6);
    checkOutput({tag, "_count"}, obsDat.size(), expDat.size());
    n = (obsDat.size() < expDat.size()) ? obsDat.size() : expDat.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), obsDat[i], expDat[i]);
      checkOutput($sformatf("%s_cycle%0d", tag, i), obsCyc[i], expCyc[i]);
    end
    obsDat.delete();
    obsCyc.delete();
    expDat.delete();
    expCyc.delete();
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    sel   = 1'b0;
    dato  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data", odata, 13'h0);
    checkOutput("rst_valid", ovalid, 1'b0);
    checkOutput("rst_kok", kernelOk, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Balanced kernel: sum is zero for a flat 0x7F image.
    kcol(col(8'h00, 8'h20, 8'h00));
    kcol(col(8'h20, 8'h80, 8'h20));
    checkOutput("t1_kok_partial", kernelOk, 1'b0);
    kcol(col(8'h00, 8'h20, 8'h00));
    checkOutput("t1_kok", kernelOk, 1'b1);
    icol(col(8'h7F, 8'h7F, 8'h7F), 1'b0, 13'h0);
    icol(col(8'h7F, 8'h7F, 8'h7F), 1'b0, 13'h0);
    icol(col(8'h7F, 8'h7F, 8'h7F), 1'b1, 13'h1000);
    icol(col(8'h7F, 8'h7F, 8'h7F), 1'b1, 13'h1000);
    drainCheck("t1");

    // Centre-only 0.5 kernel, loaded by a mid-RUN reload.
    kcol(col(8'h00, 8'h00, 8'h00));
    checkOutput("t2_kok_reload", kernelOk, 1'b0);
    kcol(col(8'h00, 8'h40, 8'h00));
    kcol(col(8'h00, 8'h00, 8'h00));
    checkOutput("t2_kok", kernelOk, 1'b1);
    icol(col(8'h00, 8'h00, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h64, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h00, 8'h00), 1'b1, 13'h1032);
    icol(col(8'h00, 8'h65, 8'h00), 1'b1, 13'h1000);
    icol(col(8'h00, 8'h00, 8'h00), 1'b1, EXP_ODD_HALF);
    drainCheck("t2");

    // Centre -1 kernel against 0x7F: most negative product.
    kcol(col(8'h00, 8'h00, 8'h00));
    kcol(col(8'h00, 8'h80, 8'h00));
    kcol(col(8'h00, 8'h00, 8'h00));
    icol(col(8'h00, 8'h00, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h7F, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h00, 8'h00), 1'b1, 13'h0F81);
    drainCheck("t3");

    // Image columns before the kernel is complete are dropped.
    kcol(col(8'h00, 8'h00, 8'h00));
    kcol(col(8'h00, 8'h40, 8'h00));
    for (int i = 0; i < 3; i++) icol(col(8'h00, 8'h7F, 8'h00), 1'b0, 13'h0);
    checkOutput("t4_kok_partial", kernelOk, 1'b0);
    kcol(col(8'h00, 8'h00, 8'h00));
    checkOutput("t4_kok", kernelOk, 1'b1);
    icol(col(8'h00, 8'h10, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h20, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h30, 8'h00), 1'b1, 13'h1010);
    drainCheck("t4");

    // Back-to-back stream, then gapped columns; result = previous centre / 2.
    for (int i = 0; i < 10; i++) begin
      icol(col(8'h00, 8'(2 * (i + 1)), 8'h00), 1'b1, (i == 0) ? 13'h1018 : 13'(13'h1000 + i));
    end
    idle(1);
    icol(col(8'h00, 8'h0A, 8'h00), 1'b1, 13'h100A);
    idle(2);
    icol(col(8'h00, 8'h0C, 8'h00), 1'b1, 13'h1005);
    idle(1);
    icol(col(8'h00, 8'h0E, 8'h00), 1'b1, 13'h1006);
    drainCheck("t5");

    // Kernel reload with two results in flight: both drain using the old kernel.
    icol(col(8'h00, 8'h40, 8'h00), 1'b1, 13'h1007);
    icol(col(8'h00, 8'h20, 8'h00), 1'b1, 13'h1020);
    kcol(col(8'h7F, 8'h7F, 8'h7F));
    checkOutput("t6_kok_reload", kernelOk, 1'b0);
    drainCheck("t6");

    // Async reset with launches in flight: nothing may come out afterwards.
    kcol(col(8'h00, 8'h40, 8'h00));
    kcol(col(8'h00, 8'h00, 8'h00));
    checkOutput("t6_kok", kernelOk, 1'b1);
    for (int i = 0; i < 4; i++) icol(col(8'h00, 8'h7E, 8'h00), 1'b0, 13'h0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_data", odata, 13'h0);
    checkOutput("t6_rst_valid", ovalid, 1'b0);
    checkOutput("t6_rst_kok", kernelOk, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) icol(col(8'h00, 8'h7E, 8'h00), 1'b0, 13'h0);
    checkOutput("t6_post_kok", kernelOk, 1'b0);
    drainCheck("t6_rst");

    // Reload and refill after reset.
    kcol(col(8'h00, 8'h00, 8'h00));
    kcol(col(8'h00, 8'h40, 8'h00));
    kcol(col(8'h00, 8'h00, 8'h00));
    icol(col(8'h00, 8'h7E, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h7E, 8'h00), 1'b0, 13'h0);
    icol(col(8'h00, 8'h7E, 8'h00), 1'b1, 13'h103F);
    drainCheck("t6_refill");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
